// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer logic on both clock domains.
package fifo_pkg;

  // Pointer helpers work on a zero-extended word, so any pointer width up to this one is supported.
  localparam int MAX_PTR_WIDTH = 32;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Prefix XOR from the MSB down, built from log2(width) shift stages.
  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] gray);
    logic [MAX_PTR_WIDTH-1:0] bin;
    bin = gray;
    for (int s = 1; s < MAX_PTR_WIDTH; s = s << 1) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared by the write and read pointer blocks.
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(MAX_PTR_WIDTH'(gray)));

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, full/almost-full flags, fill level and sticky overflow for the async FIFO.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL =
    PTR_W'((AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] lvl_next;
  logic [ADDR_WIDTH:0] full_ptr;

  assign wen        = winc & ~wfull;
  assign waddr      = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + PTR_W'(wen);
  assign wgray_next = PTR_W'(bin2gray(MAX_PTR_WIDTH'(wbin_next)));

  gray2bin_conv #(
    .WIDTH(PTR_W)
  ) u_rptr_conv (
    .gray(wq2_rptr),
    .bin (rbin)
  );

  // Level uses the synchronized (stale) read pointer, so it can only overestimate.
  assign lvl_next = wbin_next - rbin;
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign full_ptr = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};

  // NOTE: state registers use non-blocking assignments so every flag sees the same pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_ptr);
      wlevel       <= lvl_next;
      walmost_full <= (lvl_next >= AFULL_LVL);
      woverflow    <= woverflow | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Randomized scoreboard bench for wptr_full against an occupancy-count reference model.
module tb_wptr_full;

  localparam int AW     = 4;
  localparam int PW     = AW + 1;
  localparam int DEPTH  = 16;
  localparam int THRESH = 14;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic [PW-1:0] wq2_rptr = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          woverflow;

  wptr_full #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(THRESH)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit wen;
    int waddr;
    int wptr;
    bit wfull;
    bit waf;
    int wlevel;
    bit wovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: total writes accepted and total reads seen, as plain counts.
  int wr_cnt;
  int rd_cnt;
  bit full_m;
  bit ovf_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & ((1 << PW) - 1);
  endfunction

  task automatic model_reset();
    wr_cnt = 0;
    rd_cnt = 0;
    full_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  // One cycle of stimulus: inputs change on the falling edge, expectation queued for the monitor.
  task automatic step(input int wpct, input int rpct);
    exp_t e;
    bit   wi;
    @(negedge wclk);
    wi = ($urandom_range(99) < wpct);
    if (rd_cnt < wr_cnt && $urandom_range(99) < rpct) rd_cnt++;
    winc     = wi;
    wq2_rptr = PW'(gray_of(rd_cnt % (2 * DEPTH)));
    e.wen   = wi && !full_m;
    e.waddr = wr_cnt % DEPTH;
    if (wi && full_m) ovf_m = 1'b1;
    if (e.wen) wr_cnt++;
    full_m   = ((wr_cnt - rd_cnt) == DEPTH);
    e.wptr   = gray_of(wr_cnt % (2 * DEPTH));
    e.wfull  = full_m;
    e.wlevel = wr_cnt - rd_cnt;
    e.waf    = ((wr_cnt - rd_cnt) >= THRESH);
    e.wovf   = ovf_m;
    sb_q.push_back(e);
  endtask

  task automatic drain_scoreboard();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge wclk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wptr"}, wptr, 0);
    check({tag, "_waddr"}, waddr, 0);
    check({tag, "_wfull"}, wfull, 0);
    check({tag, "_walmost_full"}, walmost_full, 0);
    check({tag, "_wlevel"}, wlevel, 0);
    check({tag, "_woverflow"}, woverflow, 0);
  endtask

  task automatic run_phase(input int cycles, input int wpct, input int rpct);
    for (int i = 0; i < cycles; i++) step(wpct, rpct);
  endtask

  // Monitor: combinational outputs before the edge, registered outputs just after it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge wclk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q[0];
        check("wen", wen, e.wen);
        check("waddr", waddr, e.waddr);
        @(posedge wclk);
        #1;
        e = sb_q.pop_front();
        check("wptr", wptr, e.wptr);
        check("wfull", wfull, e.wfull);
        check("walmost_full", walmost_full, e.waf);
        check("wlevel", wlevel, e.wlevel);
        check("woverflow", woverflow, e.wovf);
      end
    end
  end

  initial begin : driver
    model_reset();
    wrst_n   = 1'b0;
    winc     = 1'b1;
    wq2_rptr = '0;
    repeat (3) @(posedge wclk);
    #1;
    check_all_zero("reset");
    check("reset_wen", wen, 1);

    @(negedge wclk);
    winc   = 1'b0;
    wrst_n = 1'b1;

    run_phase(20, 100, 0);   // fill to full, then overflow attempts
    run_phase(5, 0, 100);    // drain a little
    run_phase(300, 50, 50);
    run_phase(300, 90, 40);  // hovers near full, overlapping writes and reads
    drain_scoreboard();

    // Asynchronous reset between edges must clear state immediately.
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    winc     = 1'b0;
    wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;

    run_phase(18, 100, 0);
    run_phase(200, 20, 80);
    run_phase(300, 80, 60);
    run_phase(200, 60, 60);
    drain_scoreboard();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
Write-side pointer and full-flag generator for the asynchronous FIFO, in the wclk domain.
- Consumes the synchronized Gray read pointer wq2_rptr from the read-to-write synchronizer.
- Drives the dual-port RAM write address and enable.
- Produces the Gray write pointer for the write-to-read synchronizer.
- Provides full, almost-full, conservative fill-level and sticky overflow status to the write client.

Parameters:
ADDR_WIDTH, 4, RAM address bits; DEPTH = 2**ADDR_WIDTH; must be >= 2
AFULL_THRESH, 14, walmost_full asserts when level >= this value; legal range 1..DEPTH

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
winc  in  1  write request from client
wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray code, already synchronized to wclk
wen  out  1  RAM write enable = winc & ~wfull (combinational)
waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
wptr  out  ADDR_WIDTH+1  write pointer, Gray code, registered
wfull  out  1  FIFO full, registered
walmost_full  out  1  level >= AFULL_THRESH, registered
wlevel  out  ADDR_WIDTH+1  conservative occupancy 0..DEPTH, registered
woverflow  out  1  sticky flag: winc seen while wfull

Behaviour:
Clock and reset
- Single clock wclk; wrst_n is asynchronous, active-low.
- Reset (async assert) clears all registers: wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
- Reset mid-operation clears immediately; the read side must be reset in the same system reset.

Next-state logic
- wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDR_WIDTH+1).
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- rbin = Gray-to-binary of wq2_rptr.
- lvl_next = wbin_next - rbin, modulo 2**(ADDR_WIDTH+1).

Registered on each wclk edge
- wbin <= wbin_next; wptr <= wgray_next.
- wfull <= (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
- wlevel <= lvl_next.
- walmost_full <= (lvl_next >= AFULL_THRESH).
- woverflow <= woverflow | (winc & wfull).

Timing
- A write accepted at edge N: RAM writes at edge N using waddr. wptr, wfull, wlevel and walmost_full reflect that write immediately after edge N (zero extra latency).
- A wq2_rptr change is reflected in the flags one edge later.
- Flags are pessimistic because of synchronizer delay:
  - wfull may stay high after real reads, but never deasserts falsely.
  - wlevel may overestimate, but never underestimates.
- wptr changes at most one Gray bit per cycle.

Boundary conditions
- Full: winc is ignored. wen=0, wbin and wptr hold, woverflow sets.
- Last free slot: the write is accepted and wfull asserts at that same edge.
- winc together with a wq2_rptr advance: both enter the same next-state computation, so level is unchanged and wfull stays 0 if not already full.
- Wrap: wbin rolls over 2**(ADDR_WIDTH+1)-1 -> 0 seamlessly; the extra MSB distinguishes full from empty.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam DEPTH derivation;
  - functions bin2gray and gray2bin, parameterised by width.
- One sub-module, gray2bin_conv: combinational, WIDTH parameter. It is reused later by rptr_empty on the read side.
- All state lives in wptr_full.

Test Plan:
1. Reset: hold wrst_n=0 with winc=1 for 3 edges -> all outputs 0, wen=0 is not required (wfull=0 so wen=1), no state change. Release -> first winc writes waddr=0.
2. Fill with wq2_rptr=0: 16 consecutive winc -> waddr 0..15; wptr sequence 00001,00011,00010,00110,...; after the 16th edge wptr=11000, wfull=1, wlevel=16. 17th winc -> wen=0, wptr holds 11000, woverflow=1.
3. Almost-full, AFULL_THRESH=14: from empty, walmost_full rises at the edge of the 14th write (wlevel=14) and stays high through full.
4. Drain from full: drive wq2_rptr=00001 -> next edge wfull=0, wlevel=15. Then winc -> waddr=0 written, wfull=1 again.
5. Wrap: preload by writing/reading until wbin=20, wq2_rptr=gray(20)=11110. 16 writes -> wbin wraps to 4, wptr=00110, wfull=1, wlevel=16.
6. Simultaneous: at wlevel=15, winc=1 while wq2_rptr advances by one -> write accepted, wfull=0, wlevel=15 after the edge.
